// File: rtl/eth_txmac.sv
// eth_txmac: byte-wide Ethernet transmit MAC.
// Frames SoC bytes with preamble/SFD, pads short frames, appends CRC-32 FCS and enforces the IFG.
// Ports: MTxClk/Reset (async active-low) clock and reset; TxData/TxDataValid/TxEndFrame/TxReady SoC byte stream;
// PadEn/CrcEn per-frame options sampled at frame start; MaxFL/HugEn oversize limit;
// MTxD/MTxEn/MTxErr registered PHY interface; TxDone/TxAbort one-cycle completion pulses.
module eth_txmac #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FL = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic        MTxClk,
  input  logic        Reset,
  input  logic [7:0]  TxData,
  input  logic        TxDataValid,
  input  logic        TxEndFrame,
  output logic        TxReady,
  input  logic        PadEn,
  input  logic        CrcEn,
  input  logic [15:0] MaxFL,
  input  logic        HugEn,
  output logic [7:0]  MTxD,
  output logic        MTxEn,
  output logic        MTxErr,
  output logic        TxDone,
  output logic        TxAbort
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;
  localparam logic [7:0] PreN = 8'(PREAMBLE_BYTES);
  localparam logic [7:0] IfgLast = 8'(IFG_BYTES - 1);
  localparam logic [15:0] MinFl = 16'(MIN_FL);
  state_t state, nextState, afterPayload;
  logic [7:0] cnt, nextCnt, nextTxD;
  logic [15:0] byteCnt, nextByteCnt, incCnt;
  logic [31:0] crc, nextCrc, fcs;
  logic padLat, crcLat, ovf, nextPadLat, nextCrcLat, nextOvf;
  logic nextTxEn, nextTxErr, nextDone, nextAbort, stall;

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  assign incCnt = &byteCnt ? byteCnt : byteCnt + 16'd1;
  assign TxReady = (state == SFD || state == DATA) && !ovf;
  // An oversize frame has already sent its last permitted byte, so it takes the underrun abort path
  assign stall = !TxDataValid || ovf;
  assign fcs = ~crc;
  assign afterPayload = crcLat ? FCS : IFG;

  always_ff @(posedge MTxClk or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      cnt <= '0;
      byteCnt <= '0;
      crc <= '1;
      padLat <= 1'b0;
      crcLat <= 1'b0;
      ovf <= 1'b0;
      MTxD <= '0;
      MTxEn <= 1'b0;
      MTxErr <= 1'b0;
      TxDone <= 1'b0;
      TxAbort <= 1'b0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      byteCnt <= nextByteCnt;
      crc <= nextCrc;
      padLat <= nextPadLat;
      crcLat <= nextCrcLat;
      ovf <= nextOvf;
      MTxD <= nextTxD;
      MTxEn <= nextTxEn;
      MTxErr <= nextTxErr;
      TxDone <= nextDone;
      TxAbort <= nextAbort;
    end

  // The IDLE edge already puts the first 0x55 on the wire, so PREAMBLE starts counting at 1
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    nextByteCnt = byteCnt;
    nextCrc = crc;
    nextPadLat = padLat;
    nextCrcLat = crcLat;
    nextOvf = ovf;
    case (state)
      IDLE: if (TxDataValid) begin
        nextState = PREAMBLE;
        nextCnt = 8'd1;
        nextByteCnt = '0;
        nextCrc = '1;
        nextPadLat = PadEn;
        nextCrcLat = CrcEn;
        nextOvf = 1'b0;
      end
      PREAMBLE: begin
        nextCnt = cnt + 8'd1;
        if (cnt == PreN) begin
          nextState = SFD;
          nextCnt = '0;
        end
      end
      SFD, DATA: begin
        nextCnt = '0;
        if (stall) nextState = IFG;
        else begin
          nextByteCnt = incCnt;
          nextCrc = crcByte(crc, TxData);
          nextOvf = !TxEndFrame && !HugEn && incCnt == MaxFL;
          nextState = !TxEndFrame ? DATA : (padLat && incCnt < MinFl) ? PAD : afterPayload;
        end
      end
      PAD: begin
        nextByteCnt = incCnt;
        nextCrc = crcByte(crc, 8'h00);
        if (incCnt >= MinFl) nextState = afterPayload;
      end
      FCS: begin
        nextCnt = cnt + 8'd1;
        if (cnt == 8'd3) begin
          nextState = IFG;
          nextCnt = '0;
        end
      end
      IFG: begin
        nextCnt = cnt + 8'd1;
        if (cnt == IfgLast) begin
          nextState = IDLE;
          nextCnt = '0;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Values loaded into the PHY output registers at the end of the current cycle
  always_comb begin
    nextTxD = '0;
    nextTxEn = 1'b0;
    nextTxErr = 1'b0;
    nextDone = 1'b0;
    nextAbort = 1'b0;
    case (state)
      IDLE: begin
        nextTxEn = TxDataValid;
        nextTxD = TxDataValid ? 8'h55 : 8'h00;
      end
      PREAMBLE: begin
        nextTxEn = 1'b1;
        nextTxD = cnt == PreN ? 8'hD5 : 8'h55;
      end
      SFD, DATA: begin
        nextTxEn = 1'b1;
        nextTxErr = stall;
        nextAbort = stall;
        nextTxD = stall ? 8'h00 : TxData;
        nextDone = !stall && nextState == IFG;
      end
      PAD: begin
        nextTxEn = 1'b1;
        nextDone = nextState == IFG;
      end
      FCS: begin
        nextTxEn = 1'b1;
        nextTxD = fcs[{cnt[1:0], 3'b000} +: 8];
        nextDone = cnt == 8'd3;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_eth_txmac.sv
// tb_eth_txmac: directed self-checking bench for eth_txmac.
module tb_eth_txmac;
  logic MTxClk = 1'b0;
  logic Reset = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic TxDataValid = 1'b0, TxEndFrame = 1'b0, PadEn = 1'b0, CrcEn = 1'b1, HugEn = 1'b1;
  logic [15:0] MaxFL = 16'd1518;
  logic TxReady, MTxEn, MTxErr, TxDone, TxAbort;
  logic [7:0] MTxD;
  int checks = 0, failures = 0;
  logic [7:0] src [0:255];
  bit logOn = 1'b0;
  logic [7:0] dQ[$];
  bit enQ[$], errQ[$], doneQ[$], abortQ[$];
  int s, s2;

  always #5 MTxClk = ~MTxClk;

  eth_txmac dut (
    .MTxClk(MTxClk), .Reset(Reset), .TxData(TxData), .TxDataValid(TxDataValid),
    .TxEndFrame(TxEndFrame), .TxReady(TxReady), .PadEn(PadEn), .CrcEn(CrcEn),
    .MaxFL(MaxFL), .HugEn(HugEn), .MTxD(MTxD), .MTxEn(MTxEn), .MTxErr(MTxErr),
    .TxDone(TxDone), .TxAbort(TxAbort)
  );

  always @(negedge MTxClk)
    if (logOn) begin
      dQ.push_back(MTxD);
      enQ.push_back(MTxEn);
      errQ.push_back(MTxErr);
      doneQ.push_back(TxDone);
      abortQ.push_back(TxAbort);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic startLog();
    @(negedge MTxClk);
    #1;
    dQ.delete();
    enQ.delete();
    errQ.delete();
    doneQ.delete();
    abortQ.delete();
    logOn = 1'b1;
  endtask

  task automatic stopLog(input int cycles);
    repeat (cycles) @(posedge MTxClk);
    #1 logOn = 1'b0;
  endtask

  // Offers src[0..n-1]; gives up when the MAC aborts; leaves TxDataValid at holdValid afterwards
  task automatic drive(input int n, input bit withEnd, input bit holdValid);
    int idx;
    bit acc, aborted;
    idx = 0;
    aborted = 1'b0;
    TxData = src[0];
    TxEndFrame = withEnd && n == 1;
    TxDataValid = 1'b1;
    for (int t = 0; t < 1000 && idx < n && !aborted; t++) begin
      @(negedge MTxClk);
      aborted = TxAbort;
      acc = TxReady;
      if (!aborted) begin
        @(posedge MTxClk);
        #1;
        if (acc) begin
          idx++;
          if (idx < n) begin
            TxData = src[idx];
            TxEndFrame = withEnd && idx == n - 1;
          end
        end
      end
    end
    if (!aborted && idx < n) check("drive.budget", idx, n);
    TxDataValid = holdValid;
    TxEndFrame = 1'b0;
    TxData = 8'h00;
  endtask

  function automatic logic [7:0] wb(input int i);
    return (i >= 0 && i < dQ.size()) ? dQ[i] : 8'h00;
  endfunction

  function automatic int firstEn(input int from);
    for (int i = from; i < enQ.size(); i++) if (enQ[i]) return i;
    return -1;
  endfunction

  function automatic int runLen(input int st);
    int n = 0;
    while (st + n < enQ.size() && enQ[st + n]) n++;
    return n;
  endfunction

  function automatic int gapAfter(input int st);
    int n = 0;
    while (st + n < enQ.size() && !enQ[st + n]) n++;
    return n;
  endfunction

  function automatic bit flagAt(input int which, input int i);
    return which == 0 ? doneQ[i] : which == 1 ? errQ[i] : abortQ[i];
  endfunction

  function automatic int firstFlag(input int which, input int st);
    for (int i = st; i < enQ.size(); i++) if (flagAt(which, i)) return i - st;
    return -1;
  endfunction

  function automatic int countFlag(input int which);
    int n = 0;
    for (int i = 0; i < enQ.size(); i++) if (flagAt(which, i)) n++;
    return n;
  endfunction

  function automatic int preErrs(input int st);
    int n = 0;
    for (int i = 0; i < 7; i++) if (wb(st + i) != 8'h55) n++;
    if (wb(st + 7) != 8'hD5) n++;
    return n;
  endfunction

  function automatic int dataErrs(input int at, input int n);
    int e = 0;
    for (int i = 0; i < n; i++) if (wb(at + i) != src[i]) e++;
    return e;
  endfunction

  function automatic int zeroErrs(input int at, input int n);
    int e = 0;
    for (int i = 0; i < n; i++) if (wb(at + i) != 8'h00) e++;
    return e;
  endfunction

  function automatic logic [31:0] wireFcs(input int st, input int len);
    return {wb(st + len - 1), wb(st + len - 2), wb(st + len - 3), wb(st + len - 4)};
  endfunction

  // Bit-serial reference CRC over src[0..n-1] followed by zero padding up to padTo bytes
  function automatic logic [31:0] refFcs(input int n, input int padTo);
    logic [31:0] c;
    logic [7:0] d;
    bit fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < (n > padTo ? n : padTo); i++) begin
      d = i < n ? src[i] : 8'h00;
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic findStart(input string tag, input int from, output int st);
    st = firstEn(from);
    check({tag, ".found"}, st >= 0, 1);
    if (st < 0) st = 0;
  endtask

  task automatic frameCheck(input string tag, input int st, input int n, input int padTo, input bit crc, input int expLen);
    int body;
    body = n > padTo ? n : padTo;
    check({tag, ".len"}, runLen(st), expLen);
    check({tag, ".pre"}, preErrs(st), 0);
    check({tag, ".data"}, dataErrs(st + 8, n), 0);
    if (body > n) check({tag, ".pad"}, zeroErrs(st + 8 + n, body - n), 0);
    if (crc) check({tag, ".fcs"}, wireFcs(st, expLen), refFcs(n, padTo));
    check({tag, ".done"}, firstFlag(0, st), expLen - 1);
    check({tag, ".err"}, countFlag(1), 0);
  endtask

  task automatic loadAscii();
    for (int i = 0; i < 9; i++) src[i] = 8'(8'h31 + i);
  endtask

  task automatic loadPattern(input int n, input int mul, input int add);
    for (int i = 0; i < n; i++) src[i] = 8'(i * mul + add);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge MTxClk);
    #1;
    check("rst.MTxD", MTxD, 8'h00);
    check("rst.MTxEn", MTxEn, 1'b0);
    check("rst.MTxErr", MTxErr, 1'b0);
    check("rst.TxReady", TxReady, 1'b0);
    check("rst.pulses", {TxDone, TxAbort}, 2'b00);
    @(negedge MTxClk);
    Reset = 1'b1;

    loadAscii();
    PadEn = 1'b0;
    CrcEn = 1'b1;
    startLog();
    drive(9, 1'b1, 1'b0);
    stopLog(30);
    findStart("t1", 0, s);
    frameCheck("t1", s, 9, 0, 1'b1, 21);
    check("t1.fcsConst", wireFcs(s, 21), 32'hCBF43926);
    check("t1.byte8", wb(s + 8), 8'h31);
    check("t1.byte16", wb(s + 16), 8'h39);
    check("t1.ifg", gapAfter(s + 21) >= 12, 1'b1);

    loadPattern(14, 37, 5);
    PadEn = 1'b1;
    startLog();
    drive(14, 1'b1, 1'b0);
    stopLog(80);
    findStart("t2", 0, s);
    frameCheck("t2", s, 14, 60, 1'b1, 72);

    loadPattern(64, 11, 200);
    startLog();
    drive(64, 1'b1, 1'b0);
    stopLog(30);
    findStart("t3a", 0, s);
    frameCheck("t3a", s, 64, 60, 1'b1, 76);
    CrcEn = 1'b0;
    startLog();
    drive(64, 1'b1, 1'b0);
    stopLog(30);
    findStart("t3b", 0, s);
    frameCheck("t3b", s, 64, 60, 1'b0, 72);

    loadPattern(20, 3, 9);
    PadEn = 1'b0;
    CrcEn = 1'b1;
    startLog();
    drive(20, 1'b0, 1'b0);
    stopLog(30);
    findStart("t4", 0, s);
    check("t4.len", runLen(s), 29);
    check("t4.data", dataErrs(s + 8, 20), 0);
    check("t4.errAt", firstFlag(1, s), 28);
    check("t4.abortAt", firstFlag(2, s), 28);
    check("t4.errCount", countFlag(1), 1);
    check("t4.noDone", countFlag(0), 0);
    check("t4.idle", firstEn(s + 29), -1);

    loadPattern(150, 7, 1);
    HugEn = 1'b0;
    MaxFL = 16'd100;
    startLog();
    drive(150, 1'b1, 1'b0);
    stopLog(30);
    findStart("t5a", 0, s);
    check("t5a.len", runLen(s), 109);
    check("t5a.data", dataErrs(s + 8, 100), 0);
    check("t5a.errAt", firstFlag(1, s), 108);
    check("t5a.abortAt", firstFlag(2, s), 108);
    check("t5a.noDone", countFlag(0), 0);
    check("t5a.idle", firstEn(s + 109), -1);
    HugEn = 1'b1;
    startLog();
    drive(150, 1'b1, 1'b0);
    stopLog(30);
    findStart("t5b", 0, s);
    frameCheck("t5b", s, 150, 0, 1'b1, 162);
    MaxFL = 16'd1518;

    loadAscii();
    startLog();
    drive(9, 1'b1, 1'b1);
    drive(9, 1'b1, 1'b0);
    stopLog(40);
    findStart("t6", 0, s);
    check("t6.len1", runLen(s), 21);
    check("t6.gap", gapAfter(s + 21), 12);
    findStart("t6b", s + 21, s2);
    frameCheck("t6b", s2, 9, 0, 1'b1, 21);
    check("t6b.fcsConst", wireFcs(s2, 21), 32'hCBF43926);

    TxData = 8'hA5;
    TxEndFrame = 1'b0;
    TxDataValid = 1'b1;
    repeat (14) @(posedge MTxClk);
    #1;
    check("t7.inData", {MTxEn, MTxD, TxReady}, {1'b1, 8'hA5, 1'b1});
    #2 Reset = 1'b0;
    #1;
    check("t7.rstEn", MTxEn, 1'b0);
    check("t7.rstD", MTxD, 8'h00);
    check("t7.rstReady", TxReady, 1'b0);
    TxDataValid = 1'b0;
    repeat (2) @(posedge MTxClk);
    loadAscii();
    startLog();
    Reset = 1'b1;
    drive(9, 1'b1, 1'b0);
    stopLog(30);
    check("t7.noIfg", firstEn(0), 0);
    frameCheck("t7", 0, 9, 0, 1'b1, 21);
    check("t7.fcsConst", wireFcs(0, 21), 32'hCBF43926);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_txmac.md
Name: eth_txmac

Overview:
- Byte-wide Ethernet transmit MAC, the transmit-side counterpart of the receive MAC path.
- Accepts frame bytes (DA, SA, type/length, payload) from the SoC over a valid/ready stream.
- Emits preamble, SFD, data, zero-padding to minimum length, and the CRC-32 FCS toward the PHY.
- Enforces the inter-frame gap between frames.

Parameters:
- PREAMBLE_BYTES, 7, number of 0x55 bytes before SFD.
- MIN_FL, 60, minimum frame length (excl. FCS) when padding is enabled.
- IFG_BYTES, 12, idle byte-times after each frame.

Ports:
- MTxClk  in  1  transmit clock, one byte per cycle.
- Reset  in  1  asynchronous, active-low reset.
- TxData  in  8  frame byte from SoC.
- TxDataValid  in  1  TxData valid.
- TxEndFrame  in  1  marks last byte of frame; qualified by TxDataValid.
- TxReady  out  1  byte accepted when TxDataValid & TxReady.
- PadEn  in  1  pad short frames to MIN_FL; sampled at frame start.
- CrcEn  in  1  append FCS; sampled at frame start.
- MaxFL  in  16  maximum frame length (excl. FCS).
- HugEn  in  1  disable MaxFL check.
- MTxD  out  8  byte to PHY, registered.
- MTxEn  out  1  transmit enable, registered.
- MTxErr  out  1  transmit error to PHY, registered.
- TxDone  out  1  one-cycle pulse, frame completed normally.
- TxAbort  out  1  one-cycle pulse, frame aborted (underrun or oversize).

Behaviour:
- Reset (async, low): state IDLE, all counters 0, CRC reg 0xFFFFFFFF. MTxD=0x00, MTxEn=0, MTxErr=0, TxReady=0, TxDone=0, TxAbort=0. Reset mid-frame truncates immediately; no IFG is enforced after reset release.
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG. State and output registers update on the same MTxClk edge.
- IDLE:
  - TxReady=0.
  - When TxDataValid=1, latch PadEn/CrcEn, then ->PREAMBLE. The first byte is not consumed.
  - Next edge: MTxEn=1, MTxD=0x55.
- PREAMBLE: emits PREAMBLE_BYTES x 0x55, then ->SFD.
- SFD:
  - Emits 0xD5.
  - TxReady=1 combinationally, so the first data byte is accepted in this cycle.
  - ->DATA.
- DATA:
  - TxReady=1 (combinational from state).
  - Accepted byte appears on MTxD at the next edge: one-cycle latency.
  - ByteCnt (16b) increments per accepted byte; CRC is updated with the byte.
  - On accepted byte with TxEndFrame=1:
    - ->PAD if PadEn & ByteCnt+1 < MIN_FL;
    - else ->FCS if CrcEn;
    - else ->IFG.
  - Underrun: TxDataValid=0 in DATA. Next edge MTxErr=1 and MTxEn=1 for one cycle, TxAbort pulses, CRC is not sent, ->IFG.
  - Oversize: HugEn=0 and an accepted byte makes ByteCnt == MaxFL without TxEndFrame. That byte is sent, then the underrun abort sequence runs. Remaining SoC bytes are not accepted; the SoC must flush them.
- PAD:
  - TxReady=0.
  - Emits 0x00, updating CRC, until ByteCnt == MIN_FL.
  - Then ->FCS if CrcEn, else ->IFG.
- FCS:
  - CRC is IEEE 802.3 CRC-32: reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wide update LSB-first.
  - FCS = ~CRC, sent over 4 cycles as bits [7:0], [15:8], [23:16], [31:24].
  - TxDone pulses in the cycle the last FCS byte is on MTxD (or with the last data/pad byte when CrcEn=0).
- IFG:
  - MTxEn=0, MTxD=0x00, MTxErr=0, TxReady=0 for IFG_BYTES cycles, then ->IDLE.
  - TxDataValid during IFG is held off.
- Wire length: 8 + max(N, MIN_FL if PadEn) + 4·CrcEn bytes, MTxEn continuously high over that span.
- Back-to-back: next frame starts no earlier than IFG_BYTES+1 cycles after the last MTxEn=1 cycle.
- ByteCnt saturates at 0xFFFF. CRC is reinitialised to 0xFFFFFFFF on entry to PREAMBLE.

Test Plan:
- Frame ASCII "123456789" (9 bytes), PadEn=0, CrcEn=1, continuous valid -> MTxD = 7x55, D5, 31..39, 26 39 F4 CB. MTxEn high for 21 cycles, TxDone on the CB cycle, then 12 idle cycles.
- 14-byte frame, PadEn=1, CrcEn=1 -> 46 bytes of 0x00 after the data, 60 data+pad bytes total. FCS matches a reference CRC over the padded frame. MTxEn high for 72 cycles.
- 64-byte frame, PadEn=1 -> no padding, 76 MTxEn cycles. Same frame with CrcEn=0 -> 72 cycles, TxDone on the last data byte.
- TxDataValid dropped after 20 data bytes -> next cycle MTxErr=1 and MTxEn=1, TxAbort pulse, no FCS, 12 idle cycles, then IDLE.
- HugEn=0, MaxFL=100, 150-byte source -> 100 bytes sent, then MTxErr cycle and TxAbort. HugEn=1 -> all 150 bytes plus FCS sent.
- Two frames with TxDataValid held high across the gap -> exactly 12 cycles MTxEn=0 between frames. Reset asserted mid-DATA -> outputs 0 asynchronously; after release the next frame starts with a fresh preamble and correct CRC.
